// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: forwarding selects, load-use stall and branch flush for the fewcore pipeline.
// Define HAZARD_STATS_EN to enable the stall/flush cycle counters.
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FWD_STAGES   = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int SEL_W        = $clog2(FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_we,
  input  logic                  id_is_load,
  input  logic                  ex_branch_taken,
  output logic [SEL_W-1:0]      fwd_sel_rs1,
  output logic [SEL_W-1:0]      fwd_sel_rs2,
  output logic                  stall,
  output logic                  flush,
  output logic                  issue,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
);
  localparam int FC_W = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  logic [FWD_STAGES:1]   v_q, we_q, ld_q;
  logic [REG_ADDR_W-1:0] rd_q [FWD_STAGES:1];
  logic [FC_W-1:0]       fcnt_q, fcnt_d;
  logic [SEL_W-1:0]      sel1, sel2;
  logic                  stall_raw, flush_int, stall_int, issue_int;
  // Walk oldest to youngest so the youngest matching producer is the last write.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    stall_raw = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (v_q[k] && we_q[k] && rd_q[k] == id_rs1 && id_rs1 != '0) sel1 = SEL_W'(k);
      if (v_q[k] && we_q[k] && rd_q[k] == id_rs2 && id_rs2 != '0) sel2 = SEL_W'(k);
    end
    for (int k = 1; k <= LOAD_LAT; k++)
      if (id_valid && v_q[k] && we_q[k] && ld_q[k] &&
          ((rd_q[k] == id_rs1 && id_rs1 != '0) || (rd_q[k] == id_rs2 && id_rs2 != '0)))
        stall_raw = 1'b1;
  end
  always_comb begin
    flush_int = ex_branch_taken | (fcnt_q != '0);
    stall_int = stall_raw & ~flush_int;
    issue_int = id_valid & ~stall_int & ~flush_int;
    fcnt_d = ex_branch_taken ? FC_W'(FLUSH_CYCLES - 1) : (fcnt_q != '0) ? fcnt_q - 1'b1 : fcnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= '0;
      we_q   <= '0;
      ld_q   <= '0;
      fcnt_q <= '0;
      for (int k = 1; k <= FWD_STAGES; k++) rd_q[k] <= '0;
    end else begin
      for (int k = FWD_STAGES; k >= 2; k--) begin
        v_q[k]  <= v_q[k-1];
        we_q[k] <= we_q[k-1];
        ld_q[k] <= ld_q[k-1];
        rd_q[k] <= rd_q[k-1];
      end
      v_q[1]  <= issue_int;
      we_q[1] <= id_we;
      ld_q[1] <= id_is_load;
      rd_q[1] <= id_rd;
      fcnt_q  <= fcnt_d;
    end
  end
  assign fwd_sel_rs1 = reset ? '0 : sel1;
  assign fwd_sel_rs2 = reset ? '0 : sel2;
  assign stall       = ~reset & stall_int;
  assign flush       = ~reset & flush_int;
  assign issue       = ~reset & issue_int;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc_q, fc_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      sc_q <= sc_q + {31'd0, stall_int};
      fc_q <= fc_q + {31'd0, flush_int};
    end
  end
  assign stall_count = reset ? '0 : sc_q;
  assign flush_count = reset ? '0 : fc_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: table vectors, directed reset sequences and random stimulus vs a history-queue model.
module tb_hazard_fwd_ctrl;
  localparam int RW = 5;
  localparam int FS = 3;
  localparam int LL = 1;
  localparam int FC = 3;
  localparam int SW = $clog2(FS + 1);
  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_we, id_is_load, ex_branch_taken;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic [SW-1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic          stall, flush, issue;
  logic [31:0]   stall_count, flush_count;
  int            checks = 0;
  int            errors = 0;
  typedef struct { logic v; logic [RW-1:0] rd; logic we; logic ld; } ent_t;
  typedef struct { int v, rs1, rs2, rd, we, ld, br, e1, e2, es, ef, ei; } vec_t;
  ent_t        hist[$];
  int          cyc, last_br;
  logic [31:0] m_sc, m_fc;
  vec_t        tv[20];
  always #5 clk = ~clk;
  hazard_fwd_ctrl #(.REG_ADDR_W(RW), .FWD_STAGES(FS), .LOAD_LAT(LL), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2), .stall(stall), .flush(flush),
    .issue(issue), .stall_count(stall_count), .flush_count(flush_count)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic int m_sel(input logic [RW-1:0] rs);
    for (int i = 0; i < FS; i++)
      if (hist[i].v && hist[i].we && hist[i].rd == rs && rs != 0) return i + 1;
    return 0;
  endfunction
  function automatic logic m_flush();
    return ex_branch_taken || (cyc - last_br < FC);
  endfunction
  function automatic logic m_stall_raw();
    for (int i = 0; i < LL; i++)
      if (id_valid && hist[i].v && hist[i].we && hist[i].ld &&
          ((hist[i].rd == id_rs1 && id_rs1 != 0) || (hist[i].rd == id_rs2 && id_rs2 != 0)))
        return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < FS; i++) hist.push_back('{1'b0, '0, 1'b0, 1'b0});
    cyc = 0;
    last_br = -1000;
    m_sc = 0;
    m_fc = 0;
  endtask
  task automatic check_model();
    logic f, s, i;
    int s1, s2;
    logic [31:0] esc, efc;
    f = m_flush();
    s = m_stall_raw() && !f;
    i = id_valid && !s && !f;
    s1 = m_sel(id_rs1);
    s2 = m_sel(id_rs2);
`ifdef HAZARD_STATS_EN
    esc = m_sc;
    efc = m_fc;
`else
    esc = 0;
    efc = 0;
`endif
    if (reset) begin
      f = 0; s = 0; i = 0; s1 = 0; s2 = 0; esc = 0; efc = 0;
    end
    chk("m_sel1", 32'(fwd_sel_rs1), 32'(s1));
    chk("m_sel2", 32'(fwd_sel_rs2), 32'(s2));
    chk("m_stall", 32'(stall), 32'(s));
    chk("m_flush", 32'(flush), 32'(f));
    chk("m_issue", 32'(issue), 32'(i));
    chk("m_stall_count", stall_count, esc);
    chk("m_flush_count", flush_count, efc);
  endtask
  task automatic tick();
    logic f, s;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      f = m_flush();
      s = m_stall_raw() && !f;
      hist.push_front('{id_valid && !s && !f, id_rd, id_we, id_is_load});
      void'(hist.pop_back());
      if (ex_branch_taken) last_br = cyc;
      m_sc += 32'(s);
      m_fc += 32'(f);
      cyc++;
    end
    #1;
  endtask
  task automatic step();
    @(negedge clk);
    check_model();
    tick();
  endtask
  task automatic drive(input int v, input int r1, input int r2, input int rd,
                       input int we, input int ld, input int br);
    id_valid = v != 0;
    id_rs1 = RW'(r1);
    id_rs2 = RW'(r2);
    id_rd = RW'(rd);
    id_we = we != 0;
    id_is_load = ld != 0;
    ex_branch_taken = br != 0;
  endtask
  initial begin
    // v rs1 rs2 rd we ld br | sel1 sel2 stall flush issue
    tv[0]  = '{1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[1]  = '{1, 5, 0, 6, 1, 0, 0, 1, 0, 0, 0, 1};
    tv[2]  = '{1, 0, 5, 0, 0, 0, 0, 0, 2, 0, 0, 1};
    tv[3]  = '{1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 1};
    tv[4]  = '{1, 7, 0, 8, 1, 0, 0, 1, 0, 1, 0, 0};
    tv[5]  = '{1, 7, 0, 8, 1, 0, 0, 2, 0, 0, 0, 1};
    tv[6]  = '{1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[7]  = '{1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[8]  = '{1, 3, 3, 0, 1, 0, 0, 1, 1, 0, 0, 1};
    tv[9]  = '{1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[10] = '{1, 9, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    tv[11] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    tv[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tv[15] = '{1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 1};
    tv[16] = '{1, 4, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    tv[17] = '{1, 4, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0};
    tv[18] = '{1, 4, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0};
    tv[19] = '{1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    model_reset();
    reset = 1'b1;
    drive(1, 1, 1, 1, 1, 1, 1);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(tv[i].v, tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].we, tv[i].ld, tv[i].br);
      @(negedge clk);
      chk($sformatf("row%0d_sel1", i), 32'(fwd_sel_rs1), 32'(tv[i].e1));
      chk($sformatf("row%0d_sel2", i), 32'(fwd_sel_rs2), 32'(tv[i].e2));
      chk($sformatf("row%0d_stall", i), 32'(stall), 32'(tv[i].es));
      chk($sformatf("row%0d_flush", i), 32'(flush), 32'(tv[i].ef));
      chk($sformatf("row%0d_issue", i), 32'(issue), 32'(tv[i].ei));
      check_model();
      tick();
    end
    // Reset in the middle of a load-use stall with a branch pending.
    drive(1, 0, 0, 7, 1, 1, 0);
    step();
    drive(1, 7, 0, 5, 1, 0, 0);
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    check_model();
    tick();
    reset = 1'b1;
    drive(1, 7, 0, 5, 1, 0, 1);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_sel1", 32'(fwd_sel_rs1), 32'd0);
    chk("rst_counts", stall_count | flush_count, 32'd0);
    check_model();
    tick();
    reset = 1'b0;
    drive(1, 7, 0, 5, 1, 0, 0);
    @(negedge clk);
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_flush", 32'(flush), 32'd0);
    chk("post_rst_sel1", 32'(fwd_sel_rs1), 32'd0);
    chk("post_rst_issue", 32'(issue), 32'd1);
    check_model();
    tick();
    drive(1, 5, 0, 6, 1, 0, 0);
    @(negedge clk);
    chk("post_rst_fwd", 32'(fwd_sel_rs1), 32'd1);
    check_model();
    tick();
    // Reset while a multi-cycle flush is still running.
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_flush", 32'(flush), 32'd0);
    chk("rst_mid_flush_issue", 32'(issue), 32'd1);
    check_model();
    tick();
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 99) == 0;
      drive(int'($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 11) == 0));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
